// File: rtl/xadc_channel_sequencer.sv
// Reads the XADC status register of each accepted aux channel after its end-of-conversion and
// keeps the 12-bit codes in a 16-entry buffer. Define XADC_SEQ_AVG_EN to report 4-sample averages.
module xadc_channel_sequencer #(
    parameter logic [15:0] CH_MASK = 16'h7FFC,
    parameter logic [7:0]  TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        eoc,
    input  logic [4:0]  channel,
    output logic        drp_den,
    output logic [6:0]  drp_daddr,
    input  logic        drp_drdy,
    input  logic [15:0] drp_do,
    output logic        sample_valid,
    output logic [3:0]  sample_ch,
    output logic [11:0] sample_data,
    input  logic [3:0]  rd_ch,
    output logic [11:0] rd_data,
    output logic        overrun,
    output logic        timeout_err
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StStore} state_e;

    state_e      state_q, state_d;
    logic [3:0]  ch_q, ch_d;
    logic [11:0] code_q, code_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [3:0]  pend_ch_q, pend_ch_d;
    logic        overrun_q, overrun_d;
    logic        timeout_q, timeout_d;
    logic [11:0] res_q [16];

    logic        accept;
    logic        buf_we;
    logic [11:0] buf_wdata;

    // Status bits below the 12-bit code are not used.
    logic        unused_do_lsb;
    assign unused_do_lsb = ^drp_do[3:0];

    assign accept = eoc & channel[4] & CH_MASK[channel[3:0]];

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        code_d    = code_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_ch_d = pend_ch_q;
        overrun_d = overrun_q;
        timeout_d = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (pend_q) begin
                    ch_d    = pend_ch_q;
                    pend_d  = 1'b0;
                    state_d = StIssue;
                end else if (accept) begin
                    ch_d    = channel[3:0];
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (drp_drdy) begin
                    code_d  = drp_do[15:4];
                    state_d = StStore;
                end else if (cnt_q == TIMEOUT) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StStore: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // An eoc not taken straight from IDLE goes to the slot; the slot being served this
        // cycle frees it, so only a slot still full when busy counts as an overrun.
        if (accept && !(state_q == StIdle && !pend_q)) begin
            if (pend_q && state_q != StIdle) begin
                overrun_d = 1'b1;
            end
            pend_d    = 1'b1;
            pend_ch_d = channel[3:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            ch_q      <= '0;
            code_q    <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            pend_ch_q <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            code_q    <= code_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_ch_q <= pend_ch_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            if (buf_we) begin
                res_q[ch_q] <= buf_wdata;
            end
        end
    end

`ifdef XADC_SEQ_AVG_EN
    logic [13:0] acc_q [16];
    logic [1:0]  acc_cnt_q [16];
    logic [13:0] acc_sum;
    logic        avg_done;
    logic        store;

    assign store    = (state_q == StStore);
    assign acc_sum  = acc_q[ch_q] + {2'b00, code_q};
    assign avg_done = (acc_cnt_q[ch_q] == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                acc_q[i]     <= '0;
                acc_cnt_q[i] <= '0;
            end
        end else if (store) begin
            if (avg_done) begin
                acc_q[ch_q]     <= '0;
                acc_cnt_q[ch_q] <= '0;
            end else begin
                acc_q[ch_q]     <= acc_sum;
                acc_cnt_q[ch_q] <= acc_cnt_q[ch_q] + 2'd1;
            end
        end
    end

    always_comb begin
        sample_valid = store & avg_done;
        sample_ch    = sample_valid ? ch_q : 4'd0;
        sample_data  = sample_valid ? acc_sum[13:2] : 12'd0;
    end
`else
    always_comb begin
        sample_valid = (state_q == StStore);
        sample_ch    = sample_valid ? ch_q : 4'd0;
        sample_data  = sample_valid ? code_q : 12'd0;
    end
`endif

    always_comb begin
        buf_we      = sample_valid;
        buf_wdata   = sample_data;
        drp_den     = (state_q == StIssue);
        drp_daddr   = (state_q != StIdle) ? {3'b001, ch_q} : 7'd0;
        rd_data     = res_q[rd_ch];
        overrun     = overrun_q;
        timeout_err = timeout_q;
    end

endmodule
